// File: rtl/five_bit_adder_pkg.sv
// Shared width and result type for the ripple-carry adder slice.
package adder_pkg;

  localparam int ADDER_WIDTH = 5;

  typedef struct packed {
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/five_bit_adder_if.sv
// Operand/result bundle between an adder slice and whatever drives it.
interface five_bit_adder_if;
  import adder_pkg::*;

  logic                   in_valid;
  logic [ADDER_WIDTH-1:0] a;
  logic [ADDER_WIDTH-1:0] b;
  logic                   carry_in;
  logic [ADDER_WIDTH-1:0] sum;
  logic                   carry_out;
  logic                   out_valid;

  modport master (
    output in_valid, a, b, carry_in,
    input  sum, carry_out, out_valid
  );

  modport slave (
    input  in_valid, a, b, carry_in,
    output sum, carry_out, out_valid
  );

endinterface

// File: rtl/five_bit_adder_full_adder.sv
// One-bit full adder cell; the ripple chain is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ cin;
  assign cout   = (a & b) | (cin & w_prop);

endmodule

// File: rtl/five_bit_adder.sv
// Registered ripple-carry adder slice: {carry_out, sum} = a + b + carry_in, one cycle latency.
module five_bit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  five_bit_adder_if.slave  bus
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  add_result_t      r_result;
  logic             r_out_valid;

  assign w_carry[0] = bus.carry_in;

  // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    full_adder u_fa (
      .a    (bus.a[gi]),
      .b    (bus.b[gi]),
      .cin  (w_carry[gi]),
      .s    (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  // Output register: result captured only on valid operands, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result.carry <= w_carry[WIDTH];
        r_result.sum   <= w_sum;
      end
    end
  end

  assign bus.sum       = r_result.sum;
  assign bus.carry_out = r_result.carry;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_five_bit_adder.sv
// Randomized self-checking bench for the registered 5-bit adder slice.
module tb_five_bit_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference state: last captured result and the valid flag expected now.
  int   exp_total;
  logic exp_vld;

  int   perm [2048];

  five_bit_adder_if bus ();

  five_bit_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Called at a falling edge: drive operands, let one rising edge pass, compare at the next falling edge.
  task automatic step(input string tag, input logic v, input int a, input int b, input int c);
    bus.in_valid = v;
    bus.a        = a[4:0];
    bus.b        = b[4:0];
    bus.carry_in = c[0];
    if (v) exp_total = a + b + c;
    exp_vld = v;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_sum"},   {27'd0, bus.sum},       exp_total % 32);
    check({tag, "_cout"},  {31'd0, bus.carry_out}, exp_total / 32);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_vld});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sum"},   {27'd0, bus.sum},       0);
    check({tag, "_cout"},  {31'd0, bus.carry_out}, 0);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 0);
  endtask

  initial begin
    int j, tmp, ra, rb, rc;
    n_checks     = 0;
    n_fail       = 0;
    exp_total    = 0;
    exp_vld      = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;

    #2;
    check_reset_state("rst_initial");

    @(negedge clk);
    rst_n = 1'b1;
    // Idle cycle out of reset keeps the reset values
    step("idle", 1'b0, 7, 9, 1);
    check({"idle_total"}, {26'd0, bus.carry_out, bus.sum}, 0);

    // Directed vectors back-to-back
    step("vec1", 1'b1, 10, 11, 0);
    step("vec2", 1'b1, 22, 14, 1);
    step("vec3", 1'b1, 15, 10, 1);
    step("max",  1'b1, 31, 31, 1);
    step("prop", 1'b1, 31, 0, 1);
    step("zero", 1'b1, 0, 0, 0);
    step("vec2b", 1'b1, 22, 14, 1);

    // Hold: operands change with in_valid low
    step("hold1", 1'b0, 3, 28, 1);
    step("hold2", 1'b0, 31, 31, 1);

    // Asynchronous reset mid-cycle with a capture pending
    step("pre_rst", 1'b1, 31, 31, 1);
    bus.in_valid = 1'b1;
    bus.a = 5'd12; bus.b = 5'd9; bus.carry_in = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    @(negedge clk);
    rst_n     = 1'b1;
    exp_total = 0;
    exp_vld   = 1'b0;

    // Exhaustive sweep of every {a,b,carry_in} in random order, with random idle gaps
    for (int i = 0; i < 2048; i++) perm[i] = i;
    for (int i = 2047; i > 0; i--) begin
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 2048; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        ra = int'($urandom_range(31, 0));
        rb = int'($urandom_range(31, 0));
        rc = int'($urandom_range(1, 0));
        step("gap", 1'b0, ra, rb, rc);
      end
      step("sweep", 1'b1, (perm[i] >> 6) & 31, (perm[i] >> 1) & 31, perm[i] & 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
